membus_arbiter: RTL and testbench
=================================

Name: membus_arbiter

Overview:
- Controller and arbiter for the shared 8-bit multiplexed address/data memory bus.
- Two requesters share the bus: the fetch unit on port 0 and the decode/execute unit on port 1.
- Grants the bus round-robin and sequences each transfer as an address phase followed by a data phase, with optional wait states.
- Returns read data with a one-cycle done pulse. Sits between the Core stages and Memory.

Parameters:
WAIT_CYCLES, 0, extra data-phase cycles per transfer; legal range 0..15
FIRST_PRIO, 0, requester favoured by the round-robin pointer after reset (0 = fetch, 1 = exec)

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous reset, active-high
req0  input  1  fetch request; held until done0
we0  input  1  fetch write enable (1 = write, 0 = read)
addr0  input  8  fetch address
wdata0  input  8  fetch write data
gnt0  output  1  fetch owns the bus
done0  output  1  one-cycle completion pulse for fetch
req1, we1, addr1, wdata1, gnt1, done1  same as port 0, for exec
rdata  output  8  read data, valid while done0 or done1 is high
bus_out  output  8  value driven onto the uniBus
bus_oe  output  1  bus_out drives uniBus when high; tristate when low
bus_in  input  8  sampled uniBus value
mem_ale  output  1  address phase strobe to Memory
mem_rd  output  1  read data-phase strobe
mem_wr  output  1  write data-phase strobe

Behaviour:
- All outputs are registered.
- Reset values: gnt0/1 = 0, done0/1 = 0, rdata = 8'h00, bus_out = 8'h00, bus_oe = 0, mem_ale = mem_rd = mem_wr = 0, state = IDLE, rr pointer = FIRST_PRIO.
- States: IDLE, ADDR, DATA, DONE, TURN (TURN only with the optional feature).
- IDLE: arbitration happens only here. If exactly one req is high, that requester wins. If both are high, the requester the rr pointer names wins. A request seen at edge T puts the block in ADDR at T+1. With no req, stay in IDLE.
- Arbitration latches owner, we, addr and wdata. Later changes on the requester's inputs are ignored until done.
- ADDR (1 cycle): bus_out = addr, bus_oe = 1, mem_ale = 1, gnt of the owner = 1.
- DATA (WAIT_CYCLES+1 cycles), write: bus_out = wdata, bus_oe = 1, mem_wr = 1.
- DATA, read: bus_oe = 0, mem_rd = 1. rdata is captured from bus_in on the edge that ends the last DATA cycle.
- DATA wait states are counted by a 4-bit counter.
- gnt stays high from ADDR through DONE.
- DONE (1 cycle): owner's done = 1; all strobes low; bus_oe = 0; rr pointer set to the other requester. Next state is IDLE, or TURN after a read when the feature is enabled.
- Latency from the request edge T to done: 3 + WAIT_CYCLES cycles, for both reads and writes.
- Minimum spacing between back-to-back transfers: 4 + WAIT_CYCLES cycles, with no turnaround.
- Handshake: a requester asserting req in IDLE starts a new transfer. To stop, it deasserts req on the edge where it sees done = 1. If req is still high in the following IDLE, that is a new request.
- If req drops mid-transfer, the transfer still completes and done still pulses.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- The rdata value persists until the next read capture. Writes do not modify rdata.
- Reset mid-transfer: on the next edge all outputs return to reset values, the transfer is abandoned with no done pulse, and the rr pointer returns to FIRST_PRIO.
- Out-of-range WAIT_CYCLES (>15) is an elaboration error.

Optional Feature:
- Macro: MEMBUS_TURNAROUND_EN.
- Defined: after a read, DONE → TURN → IDLE. TURN lasts 1 cycle with bus_oe = 0 and all strobes low. This guarantees a dead bus cycle before the block drives the next address. Read-to-next-transfer spacing grows by 1.
- Undefined: DONE → IDLE always, and the TURN state does not exist.

Test Plan:
- Fetch read, WAIT_CYCLES = 0, mem[0] = 8'h10, req0 at T with addr0 = 8'h00 → T+1: mem_ale = 1, bus_out = 8'h00; T+2: mem_rd = 1, bus_oe = 0; T+3: done0 = 1, rdata = 8'h10.
- Exec write to addr 8'hFF with data 8'hAA → ADDR shows bus_out = 8'hFF; DATA shows bus_out = 8'hAA with mem_wr = 1; done1 at T+3; a subsequent read of 8'hFF returns 8'hAA.
- req0 and req1 held continuously from reset with FIRST_PRIO = 0 → grant order 0, 1, 0, 1; a done every 4 cycles; gnt0 and gnt1 never high together.
- WAIT_CYCLES = 2, read of addr 8'h03 (mem = 8'h13) → mem_rd high for 3 cycles; done at T+5; rdata = 8'h13.
- RST asserted during the DATA state of a write → next edge: all outputs zero, state IDLE, no done pulse; then a req1-only request → granted normally.
- With MEMBUS_TURNAROUND_EN defined: a read followed by a pending req1 → one cycle with bus_oe = 0 and no strobes between DONE and the next mem_ale.

Source files
------------

// File: rtl/membus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 8-bit multiplexed memory bus.
// Optional read-to-next-transfer turnaround cycle: define MEMBUS_TURNAROUND_EN.
module membus_arbiter #(
   parameter int unsigned WAIT_CYCLES = 0,
   parameter int unsigned FIRST_PRIO  = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       req0,
   input  logic       we0,
   input  logic [7:0] addr0,
   input  logic [7:0] wdata0,
   output logic       gnt0,
   output logic       done0,
   input  logic       req1,
   input  logic       we1,
   input  logic [7:0] addr1,
   input  logic [7:0] wdata1,
   output logic       gnt1,
   output logic       done1,
   output logic [7:0] rdata,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   input  logic [7:0] bus_in,
   output logic       mem_ale,
   output logic       mem_rd,
   output logic       mem_wr
);

   generate
      if (WAIT_CYCLES > 15) begin : g_bad_wait
         $error("membus_arbiter: WAIT_CYCLES must be in 0..15");
      end
      if (FIRST_PRIO > 1) begin : g_bad_prio
         $error("membus_arbiter: FIRST_PRIO must be 0 or 1");
      end
   endgenerate

   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);
   localparam logic       RR_INIT   = 1'(FIRST_PRIO);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
`ifdef MEMBUS_TURNAROUND_EN
      S_DONE = 3'd3,
      S_TURN = 3'd4
`else
      S_DONE = 3'd3
`endif
   } state_t;

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       we_q, we_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [3:0] cnt_q, cnt_d;
   logic       rr_q, rr_d;
   logic [7:0] rdata_q, rdata_d;
   logic       grab_s;

   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       done0_q, done0_d;
   logic       done1_q, done1_d;
   logic [7:0] bus_out_q, bus_out_d;
   logic       bus_oe_q, bus_oe_d;
   logic       mem_ale_q, mem_ale_d;
   logic       mem_rd_q, mem_rd_d;
   logic       mem_wr_q, mem_wr_d;

   // State and output register bank; outputs are precomputed from next state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         cnt_q     <= 4'd0;
         rr_q      <= RR_INIT;
         rdata_q   <= 8'h00;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         bus_out_q <= 8'h00;
         bus_oe_q  <= 1'b0;
         mem_ale_q <= 1'b0;
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         rr_q      <= rr_d;
         rdata_q   <= rdata_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         bus_out_q <= bus_out_d;
         bus_oe_q  <= bus_oe_d;
         mem_ale_q <= mem_ale_d;
         mem_rd_q  <= mem_rd_d;
         mem_wr_q  <= mem_wr_d;
      end
   end

   // Next-state: arbitration in IDLE, transfer sequencing, wait count, read capture.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      rdata_d = rdata_q;
      grab_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 && req1) begin
               owner_d = rr_q;
               grab_s  = 1'b1;
            end else if (req0) begin
               owner_d = 1'b0;
               grab_s  = 1'b1;
            end else if (req1) begin
               owner_d = 1'b1;
               grab_s  = 1'b1;
            end else begin
               grab_s  = 1'b0;
            end
            // Transfer attributes are frozen here so requester changes are ignored.
            if (grab_s) begin
               state_d = S_ADDR;
               we_d    = owner_d ? we1 : we0;
               addr_d  = owner_d ? addr1 : addr0;
               wdata_d = owner_d ? wdata1 : wdata0;
               cnt_d   = 4'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            state_d = S_DATA;
            cnt_d   = 4'd0;
         end
         S_DATA: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = S_DONE;
               if (!we_q) begin
                  rdata_d = bus_in;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_DONE: begin
            rr_d = ~owner_q;
`ifdef MEMBUS_TURNAROUND_EN
            if (we_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_TURN;
            end
`else
            state_d = S_IDLE;
`endif
         end
`ifdef MEMBUS_TURNAROUND_EN
         S_TURN: begin
            state_d = S_IDLE;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every port comes straight from a flop.
   always_comb begin
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      bus_out_d = 8'h00;
      bus_oe_d  = 1'b0;
      mem_ale_d = 1'b0;
      mem_rd_d  = 1'b0;
      mem_wr_d  = 1'b0;
      case (state_d)
         S_ADDR: begin
            gnt0_d    = ~owner_d;
            gnt1_d    = owner_d;
            bus_out_d = addr_d;
            bus_oe_d  = 1'b1;
            mem_ale_d = 1'b1;
         end
         S_DATA: begin
            gnt0_d = ~owner_d;
            gnt1_d = owner_d;
            if (we_d) begin
               bus_out_d = wdata_d;
               bus_oe_d  = 1'b1;
               mem_wr_d  = 1'b1;
            end else begin
               mem_rd_d  = 1'b1;
            end
         end
         S_DONE: begin
            gnt0_d  = ~owner_d;
            gnt1_d  = owner_d;
            done0_d = ~owner_d;
            done1_d = owner_d;
         end
         default: begin
            gnt0_d = 1'b0;
         end
      endcase
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign rdata   = rdata_q;
   assign bus_out = bus_out_q;
   assign bus_oe  = bus_oe_q;
   assign mem_ale = mem_ale_q;
   assign mem_rd  = mem_rd_q;
   assign mem_wr  = mem_wr_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: a zero-wait instance plus a WAIT_CYCLES=2 instance,
// each with a small behavioural memory on the multiplexed bus.
module tb_membus_arbiter;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [7:0] addr0 = 8'h00, wdata0 = 8'h00, addr1 = 8'h00, wdata1 = 8'h00;
   logic       gnt0, gnt1, done0, done1, bus_oe, mem_ale, mem_rd, mem_wr;
   logic [7:0] rdata, bus_out, bus_in;

   logic       w2_req0 = 1'b0, w2_we0 = 1'b0;
   logic [7:0] w2_addr0 = 8'h00;
   logic       w2_gnt0, w2_gnt1, w2_done0, w2_done1, w2_bus_oe, w2_mem_ale, w2_mem_rd, w2_mem_wr;
   logic [7:0] w2_rdata, w2_bus_out, w2_bus_in;

   logic [7:0] mem [256] = '{0: 8'h10, 1: 8'h11, default: 8'h00};
   logic [7:0] mem2 [256] = '{3: 8'h13, default: 8'h00};
   logic [7:0] lat_addr = 8'h00;
   logic [7:0] lat_addr2 = 8'h00;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   membus_arbiter #(.WAIT_CYCLES(0), .FIRST_PRIO(0)) dut (
      .CLK(CLK), .RST(RST),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
      .rdata(rdata), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
      .mem_ale(mem_ale), .mem_rd(mem_rd), .mem_wr(mem_wr)
   );

   membus_arbiter #(.WAIT_CYCLES(2), .FIRST_PRIO(0)) dut_w2 (
      .CLK(CLK), .RST(RST),
      .req0(w2_req0), .we0(w2_we0), .addr0(w2_addr0), .wdata0(8'h00), .gnt0(w2_gnt0), .done0(w2_done0),
      .req1(1'b0), .we1(1'b0), .addr1(8'h00), .wdata1(8'h00), .gnt1(w2_gnt1), .done1(w2_done1),
      .rdata(w2_rdata), .bus_out(w2_bus_out), .bus_oe(w2_bus_oe), .bus_in(w2_bus_in),
      .mem_ale(w2_mem_ale), .mem_rd(w2_mem_rd), .mem_wr(w2_mem_wr)
   );

   // Memory models: latch address on ALE, write on WR, drive read data while RD.
   always @(posedge CLK) begin
      if (mem_ale) lat_addr <= bus_out;
      if (mem_wr) mem[lat_addr] <= bus_out;
      if (w2_mem_ale) lat_addr2 <= w2_bus_out;
   end
   assign bus_in    = mem_rd ? mem[lat_addr] : 8'h00;
   assign w2_bus_in = w2_mem_rd ? mem2[lat_addr2] : 8'h00;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_bus(input string tag);
      chk({tag, "_oe"}, {7'd0, bus_oe}, 8'h00);
      chk({tag, "_ale"}, {7'd0, mem_ale}, 8'h00);
      chk({tag, "_rd"}, {7'd0, mem_rd}, 8'h00);
      chk({tag, "_wr"}, {7'd0, mem_wr}, 8'h00);
   endtask

   task automatic chk_reset(input string tag);
      chk_idle_bus(tag);
      chk({tag, "_gnt"}, {6'd0, gnt1, gnt0}, 8'h00);
      chk({tag, "_done"}, {6'd0, done1, done0}, 8'h00);
      chk({tag, "_rdata"}, rdata, 8'h00);
      chk({tag, "_bus_out"}, bus_out, 8'h00);
   endtask

   initial begin
      // Reset state
      step(); step();
      chk_reset("rst");
      chk("rst_w2_rdata", w2_rdata, 8'h00);
      RST = 1'b0;
      step();

      // Fetch read of 0x00
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
      step();
      chk("rd0_ale", {7'd0, mem_ale}, 8'h01);
      chk("rd0_addr", bus_out, 8'h00);
      chk("rd0_oe_addr", {7'd0, bus_oe}, 8'h01);
      chk("rd0_gnt", {6'd0, gnt1, gnt0}, 8'h01);
      addr0 = 8'h55;
      step();
      chk("rd0_rd", {7'd0, mem_rd}, 8'h01);
      chk("rd0_oe_data", {7'd0, bus_oe}, 8'h00);
      chk("rd0_ale_data", {7'd0, mem_ale}, 8'h00);
      step();
      chk("rd0_done", {6'd0, done1, done0}, 8'h01);
      chk("rd0_rdata", rdata, 8'h10);
      chk("rd0_rd_done", {7'd0, mem_rd}, 8'h00);
      req0 = 1'b0;
      step();
      chk("rd0_pulse", {6'd0, done1, done0}, 8'h00);
      chk("rd0_gnt_rel", {6'd0, gnt1, gnt0}, 8'h00);
      chk("rd0_rdata_hold", rdata, 8'h10);

      // Exec write 0xAA to 0xFF
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'hFF; wdata1 = 8'hAA;
      step();
      chk("wr1_addr", bus_out, 8'hFF);
      chk("wr1_ale", {7'd0, mem_ale}, 8'h01);
      chk("wr1_gnt", {6'd0, gnt1, gnt0}, 8'h02);
      wdata1 = 8'h00;
      step();
      chk("wr1_data", bus_out, 8'hAA);
      chk("wr1_wr", {7'd0, mem_wr}, 8'h01);
      chk("wr1_oe", {7'd0, bus_oe}, 8'h01);
      step();
      chk("wr1_done", {6'd0, done1, done0}, 8'h02);
      chk("wr1_rdata_kept", rdata, 8'h10);
      req1 = 1'b0;
      step();

      // Exec read back 0xFF, fetch request pending behind it
      we1 = 1'b0; req1 = 1'b1;
      step();
      chk("rb1_gnt", {6'd0, gnt1, gnt0}, 8'h02);
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
      step();
      step();
      chk("rb1_done", {6'd0, done1, done0}, 8'h02);
      chk("rb1_rdata", rdata, 8'hAA);
      req1 = 1'b0;
      step();
      chk_idle_bus("gap1");
      chk("gap1_gnt", {6'd0, gnt1, gnt0}, 8'h00);
`ifdef MEMBUS_TURNAROUND_EN
      step();
      chk_idle_bus("gap2");
`endif
      step();
      chk("next_ale", {7'd0, mem_ale}, 8'h01);
      chk("next_addr", bus_out, 8'h01);
      chk("next_gnt", {6'd0, gnt1, gnt0}, 8'h01);
      step();
      step();
      chk("next_done", {6'd0, done1, done0}, 8'h01);
      chk("next_rdata", rdata, 8'h11);
      req0 = 1'b0;
      step(); step(); step();

      // WAIT_CYCLES=2 read of 0x03
      w2_req0 = 1'b1; w2_we0 = 1'b0; w2_addr0 = 8'h03;
      step();
      chk("w2_ale", {7'd0, w2_mem_ale}, 8'h01);
      for (int k = 2; k <= 4; k++) begin
         step();
         chk($sformatf("w2_rd_c%0d", k), {6'd0, w2_done0, w2_mem_rd}, 8'h01);
      end
      step();
      chk("w2_done", {6'd0, w2_done0, w2_mem_rd}, 8'h02);
      chk("w2_rdata", w2_rdata, 8'h13);
      w2_req0 = 1'b0;
      step();

      // Fairness from reset: both requesters held
      RST = 1'b1;
      step();
      RST = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h01;
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h02;
      for (int k = 1; k <= 16; k++) begin
         step();
         chk($sformatf("rr_excl_c%0d", k), {7'd0, gnt0 & gnt1}, 8'h00);
         chk($sformatf("rr_done_c%0d", k), {6'd0, done1, done0},
             {6'd0, ((k % 8) == 7), ((k % 8) == 3)});
         if (k == 1) chk("rr_first_gnt", {6'd0, gnt1, gnt0}, 8'h01);
         if (k == 5) chk("rr_second_gnt", {6'd0, gnt1, gnt0}, 8'h02);
         if (k == 15) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      step(); step();

      // Reset during the data phase of a write
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h30; wdata1 = 8'h77;
      step();
      step();
      chk("mid_wr", {7'd0, mem_wr}, 8'h01);
      RST = 1'b1; req1 = 1'b0;
      step();
      chk_reset("mid_rst");
      RST = 1'b0;
      step();
      chk("mid_no_done", {6'd0, done1, done0}, 8'h00);
      chk("mid_no_gnt", {6'd0, gnt1, gnt0}, 8'h00);
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF;
      step();
      chk("post_gnt", {6'd0, gnt1, gnt0}, 8'h02);
      chk("post_addr", bus_out, 8'hFF);
      step();
      step();
      chk("post_done", {6'd0, done1, done0}, 8'h02);
      chk("post_rdata", rdata, 8'hAA);
      req1 = 1'b0;
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
